// File: rtl/rioctrl_io_pkg.sv
// Shared types and defaults for the serial I/O chain target.
// State encoding and counter sizing live here so the top and tests agree.
package rioctrl_io_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    SHIFT   = 2'd1,
    LATCH   = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = $clog2(DEF_WIDTH + 2);

  // Counter must hold 0..WIDTH+1 (saturation marks an over-long frame).
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/rioctrl_io_sync.sv
// Multi-flop synchronizer with a trailing edge-detect register.
// All three serial inputs use this so their timing stays aligned.
module rioctrl_io_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/rioctrl_io_target.sv
// Serial chain target: shifts a word in MSB first, shifts a
// snapshot of par_in out LSB first, latches on the load strobe.
module rioctrl_io_target
  import rioctrl_io_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             load,
  input  logic             din,
  output logic             dout,
  output logic [WIDTH-1:0] par_out,
  input  logic [WIDTH-1:0] par_in,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic sclk_q, sclk_r, sclk_f;
  logic load_q, load_r, load_f;
  logic din_q, din_r, din_f;

  rioctrl_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_q), .rise(sclk_r), .fall(sclk_f)
  );

  // load idles high, so its chain resets high to avoid a false edge.
  rioctrl_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_load (
    .clk(clk), .rst(rst), .d(load),
    .q(load_q), .rise(load_r), .fall(load_f)
  );

  rioctrl_io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(clk), .rst(rst), .d(din),
    .q(din_q), .rise(din_r), .fall(din_f)
  );

  logic unused_ok;
  assign unused_ok = ^{sclk_q, load_q, din_r, din_f};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] snap;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] snap_sh;

  always_comb begin
    sr_nxt    = sr << 1;
    sr_nxt[0] = din_q;
    snap_sh   = snap >> cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARM;
      par_out    <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      snap       <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        ARM: begin
          snap  <= par_in;
          dout  <= par_in[0];
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (load_f) begin
            state <= LATCH;
          end else if (load_r) begin
            state <= ARM;
          end else begin
            if (sclk_r) begin
              sr <= sr_nxt;
              if (cnt != CNT_SAT)
                cnt <= cnt + 1'b1;
            end
            if (sclk_f)
              dout <= (cnt < CNT_FULL) ? snap_sh[0] : 1'b0;
          end
        end
        LATCH: begin
          if (cnt == CNT_FULL) begin
            par_out    <= sr;
            frame_done <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (load_r)
            state <= ARM;
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
